iterative_shift_unit: RTL and testbench
=======================================

Name: iterative_shift_unit

Overview:
Multi-cycle sequencer for MIPS sll/srl/sra (and the variable-amount forms) that sits directly upstream of the 2-bit-amount logical step shifter.
- Accepts a 32-bit operand and a 5-bit shift amount.
- Applies the shift as repeated steps of 0–3 bits, one step per clock.
- Adds sign fill for arithmetic right shifts.
- Returns the result to the ALU/writeback path with a start/busy/done handshake.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, width of the shift-amount input.
- STEP_MAX, 3, maximum bits shifted per cycle. This is fixed by the 2-bit step amount.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- operand  input  WIDTH  value to shift; sampled on the accepting edge.
- shamt  input  SHAMT_W  total shift amount (0–31); sampled on the accepting edge.
- shift_left  input  1  1 = left shift, 0 = right shift; sampled on the accepting edge.
- arith  input  1  1 = arithmetic right shift (sign fill); ignored when shift_left=1.
- busy  output  1  high while state = SHIFT.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  WIDTH  final shifted value; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE, busy = 0, done = 0, result = 0.
  - Internal data register and remaining-count register = 0.
  - A partial shift in progress is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1 on an edge: latch operand into data, shamt into rem, and latch shift_left, arith, and sign = operand[WIDTH-1].
  - Go to SHIFT.
- SHIFT:
  - On each edge: step = min(rem, 3).
  - data <= data shifted by step (left or right, logical).
  - For an arithmetic right shift, the vacated top step bits are forced to the latched sign.
  - rem <= rem − step.
  - If rem − step == 0, or rem was already 0: result <= new data, go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - If start = 1 on this edge: accept the new request (same latching as IDLE) and go to SHIFT. This gives back-to-back operation with no idle bubble.
  - Otherwise go to IDLE.
- Latency:
  - done is high in the cycle after edge E_L, where E_0 is the accepting edge and L = max(1, ceil(shamt/3)).
  - shamt = 0 gives L = 1; shamt = 31 gives L = 11.
- start while in SHIFT: ignored. No queueing; latched inputs are unaffected.
- Input changes after the accepting edge have no effect on the operation in flight.
- shamt = 0: result = operand unchanged, including for arith.
- Arithmetic right shift of a negative value fills every vacated position with 1. Repeated steps must accumulate the fill correctly; the sign comes from the latched bit, not from the current data.
- Left shift with arith = 1: behaves as a logical left shift.
- result changes only on the edge entering DONE (or on reset). It is stable in IDLE and in SHIFT.
- busy and done are never high in the same cycle.

Test Plan:
- Logical left, short: operand=0x00000001, shamt=5, shift_left=1 → steps 3 then 2, done after E_2, result=0x00000020; busy high for 2 cycles.
- Logical right, with start held high: operand=0xF0000000, shamt=4, shift_left=0, arith=0, start held high for 3 cycles → result=0x0F000000, L=2. Because start is still high during the DONE cycle, a second operation is accepted back-to-back; the starts asserted during SHIFT are ignored.
- Arithmetic right, full: operand=0x80000000, shamt=31, arith=1 → L=11, result=0xFFFFFFFF. Repeat with operand=0x7FFFFFFF → result=0x00000000.
- Zero amount: operand=0xDEADBEEF, shamt=0, arith=1 → done after E_1, result=0xDEADBEEF.
- Back-to-back requests:
  - Issue sll 0x1 by 3 (L=1). Assert start in the DONE cycle with srl 0x100 by 8.
  - Required: second done 3 cycles later, result=0x00000001; first result=0x00000008.
  - While the second operation is in SHIFT, pulse start with different operands; these are ignored.
- Reset mid-operation: start sra 0x80000000 by 31; assert rst asynchronously at cycle 5 → busy, done, result go to 0 immediately with no clock edge. After release, a new sll 0x3 by 1 gives 0x00000006 with L=1.

Source files
------------

// File: rtl/iterative_shift_unit.sv
// Multi-cycle sll/srl/sra sequencer: applies the total shift as 0..3-bit steps,
// one per clock, with sign fill for arithmetic right shifts and a start/busy/done handshake.
module iterative_shift_unit #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int STEP_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               shift_left,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   data_r;
    logic [SHAMT_W-1:0] rem_r;
    logic               left_r;
    logic               arith_r;
    logic               sign_r;
    logic [WIDTH-1:0]   result_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic [1:0]         step_s;
    logic [SHAMT_W-1:0] rem_next_s;
    logic               finish_s;
    logic               fill_s;
    logic [WIDTH-1:0]   shifted_s;

    // One 0..3-bit step; right shifts insert the fill bit into vacated top positions.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       amt,
        input logic             left,
        input logic             fill
    );
        logic [WIDTH-1:0] r;
        case (amt)
            2'd0:    r = d;
            2'd1:    r = left ? {d[WIDTH-2:0], 1'b0}   : {fill, d[WIDTH-1:1]};
            2'd2:    r = left ? {d[WIDTH-3:0], 2'b00}  : {{2{fill}}, d[WIDTH-1:2]};
            2'd3:    r = left ? {d[WIDTH-4:0], 3'b000} : {{3{fill}}, d[WIDTH-1:3]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Step selection and the next data/remaining values for the SHIFT state.
    always_comb begin
        accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        if (rem_r > SHAMT_W'(STEP_MAX)) begin
            step_s = 2'(STEP_MAX);
        end else begin
            step_s = rem_r[1:0];
        end
        rem_next_s = rem_r - {{(SHAMT_W-2){1'b0}}, step_s};
        finish_s   = (rem_next_s == {SHAMT_W{1'b0}});
        // Fill comes from the sign latched at acceptance, never from the shifting data.
        fill_s     = arith_r && !left_r && sign_r;
        shifted_s  = step_shift(data_r, step_s, left_r, fill_s);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (finish_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_SHIFT);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Operand capture, stepping datapath and result update on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r   <= {WIDTH{1'b0}};
            rem_r    <= {SHAMT_W{1'b0}};
            left_r   <= 1'b0;
            arith_r  <= 1'b0;
            sign_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            data_r   <= operand;
            rem_r    <= shamt;
            left_r   <= shift_left;
            arith_r  <= arith;
            sign_r   <= operand[WIDTH-1];
        end else if (state_r == ST_SHIFT) begin
            data_r <= shifted_s;
            rem_r  <= rem_next_s;
            if (finish_s) begin
                result_r <= shifted_s;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed scenarios plus random
// operations checked against an arithmetic shift/latency reference model.
module tb_iterative_shift_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        shift_left;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_bad;

    iterative_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP_MAX(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .operand    (operand),
        .shamt      (shamt),
        .shift_left (shift_left),
        .arith      (arith),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [31:0] op, input logic [4:0] sh,
                                                 input logic l, input logic a);
        logic signed [31:0] s;
        s = op;
        if (l) return op << sh;
        if (a) return s >>> sh;
        return op >> sh;
    endfunction

    function automatic int model_lat(input logic [4:0] sh);
        int n;
        n = (int'(sh) + 2) / 3;
        return (n < 1) ? 1 : n;
    endfunction

    // Drives one request; the next rising edge accepts it. Inputs are scrambled afterwards.
    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic l,
                         input logic a, input bit hold);
        operand = op; shamt = sh; shift_left = l; arith = a; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        operand = $urandom; shamt = 5'($urandom); shift_left = 1'($urandom); arith = 1'($urandom);
    endtask

    // Counts edges until done is seen (bounded), recording busy cycles and any busy/done overlap.
    task automatic wait_done(output int lat, output int bcnt, output bit ovl, output bit tout);
        lat = 0; bcnt = 0; ovl = 1'b0; tout = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) tout = 1'b1;
        if (busy === 1'b1 && done === 1'b1) ovl = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
    endtask

    task automatic test_left_short();
        int lat, bc; bit ov, to;
        issue(32'h1, 5'd5, 1'b1, 1'b0, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 2 || bc !== 2 || ov) begin
            n_bad++;
            $display("FAIL left_short_timing: lat=%0d busy=%0d ovl=%b to=%b, required lat=2 busy=2", lat, bc, ov, to);
        end
        n_cmp++;
        if (result !== 32'h20) begin
            n_bad++;
            $display("FAIL left_short_result: got %h, required 00000020", result);
        end
    endtask

    task automatic test_right_start_held();
        int lat, bc; bit ov, to;
        issue(32'hF000_0000, 5'd4, 1'b0, 1'b0, 1'b1);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 2 || result !== 32'h0F00_0000) begin
            n_bad++;
            $display("FAIL right_held: lat=%0d result=%h, required lat=2 result=0f000000", lat, result);
        end
        // start is still high in the DONE cycle, so this request is taken back-to-back
        operand = 32'h1234_5678; shamt = 5'd7; shift_left = 1'b0; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        operand = 32'hFFFF_FFFF; shamt = 5'd1;
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 3 || result !== model_result(32'h1234_5678, 5'd7, 1'b0, 1'b0)) begin
            n_bad++;
            $display("FAIL right_held_second: lat=%0d result=%h, required lat=3 result=%h",
                     lat, result, model_result(32'h1234_5678, 5'd7, 1'b0, 1'b0));
        end
    endtask

    task automatic test_arith_full();
        int lat, bc; bit ov, to;
        issue(32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 11 || bc !== 11 || result !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL arith_neg: lat=%0d busy=%0d result=%h, required 11 11 ffffffff", lat, bc, result);
        end
        issue(32'h7FFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 11 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL arith_pos: lat=%0d result=%h, required 11 00000000", lat, result);
        end
    endtask

    task automatic test_zero();
        int lat, bc; bit ov, to;
        issue(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 1 || result !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL zero_amount: lat=%0d result=%h, required 1 deadbeef", lat, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit ov, to;
        issue(32'h1, 5'd3, 1'b1, 1'b0, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 1 || result !== 32'h8) begin
            n_bad++;
            $display("FAIL b2b_first: lat=%0d result=%h, required 1 00000008", lat, result);
        end
        operand = 32'h100; shamt = 5'd8; shift_left = 1'b0; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h8) begin
            n_bad++;
            $display("FAIL b2b_hold: busy=%b done=%b result=%h, required 1 0 00000008", busy, done, result);
        end
        operand = 32'hFFFF_FFFF; shamt = 5'd1; shift_left = 1'b1; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || (lat + 1) !== 3 || result !== 32'h1) begin
            n_bad++;
            $display("FAIL b2b_second: lat=%0d result=%h, required 3 00000001", lat + 1, result);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit ov, to;
        issue(32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (busy !== 1'b1 || result !== 32'h1) begin
            n_bad++;
            $display("FAIL pre_reset: busy=%b result=%h, required 1 00000001", busy, result);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        issue(32'h3, 5'd1, 1'b1, 1'b0, 1'b0);
        wait_done(lat, bc, ov, to);
        n_cmp++;
        if (to || lat !== 1 || result !== 32'h6) begin
            n_bad++;
            $display("FAIL after_reset: lat=%0d result=%h, required 1 00000006", lat, result);
        end
    endtask

    task automatic test_random();
        int lat, bc; bit ov, to;
        logic [31:0] op, exp;
        logic [4:0]  sh;
        logic        l, a;
        for (int i = 0; i < 30; i++) begin
            op = $urandom;
            if (i % 3 == 0) op[31] = 1'b1;
            sh = 5'($urandom_range(0, 31));
            l  = 1'($urandom);
            a  = 1'($urandom);
            exp = model_result(op, sh, l, a);
            issue(op, sh, l, a, 1'b0);
            wait_done(lat, bc, ov, to);
            n_cmp++;
            if (to || ov || lat !== model_lat(sh) || bc !== lat || result !== exp) begin
                n_bad++;
                $display("FAIL random_%0d: op=%h sh=%0d l=%b a=%b lat=%0d busy=%0d ovl=%b result=%h, required lat=%0d result=%h",
                         i, op, sh, l, a, lat, bc, ov, result, model_lat(sh), exp);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
                n_bad++;
                $display("FAIL random_idle_%0d: done=%b busy=%b result=%h, required 0 0 %h", i, done, busy, result, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; operand = 32'h0; shamt = 5'd0; shift_left = 1'b0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_left_short();
        test_right_start_held();
        test_arith_full();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
